// File: rtl/riscv_hazard_ctrl.sv
// Hazard and operand-bypass controller for the IF/ID/EX/LSU/RUU pipeline:
// in-flight destination tracking, load-use stall, youngest-first forwarding and branch control.
module riscv_hazard_ctrl #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned LOAD_STAGE     = 1,
    parameter int unsigned BR_MODE        = 1,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   id_valid,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] id_rs_adr,
    input  logic [NUM_RD_PORTS-1:0]                id_rs_used,
    input  logic [REG_ADDR_WIDTH-1:0]              id_rd_adr,
    input  logic                                   id_rd_we,
    input  logic                                   id_is_load,
    input  logic                                   id_is_ctrl,
    input  logic [NUM_RD_PORTS*REG_WIDTH-1:0]      rf_rdata,
    input  logic [NUM_STAGES*REG_WIDTH-1:0]        stg_data,
    input  logic                                   br_resolve,
    input  logic                                   br_taken,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0]      opd,
    output logic [NUM_RD_PORTS-1:0]                fwd_hit,
    output logic                                   id_stall,
    output logic                                   if_hold,
    output logic                                   flush
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_FLUSH
    } ctrl_state_e;

    localparam logic [3:0] FLUSH_LEN = 4'(FLUSH_CYCLES);

    logic [REG_ADDR_WIDTH-1:0] trk_rd_q [NUM_STAGES];
    logic [REG_ADDR_WIDTH-1:0] trk_rd_d [NUM_STAGES];
    logic [NUM_STAGES-1:0]     trk_we_q;
    logic [NUM_STAGES-1:0]     trk_we_d;
    logic [NUM_STAGES-1:0]     trk_ld_q;
    logic [NUM_STAGES-1:0]     trk_ld_d;

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;

    logic [NUM_STAGES-1:0] match [NUM_RD_PORTS];
    logic                  load_use;
    logic                  issue;

    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                match[p][i] = id_rs_used[p]
                    && (id_rs_adr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0)
                    && trk_we_q[i]
                    && (trk_rd_q[i] == id_rs_adr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]);
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if ((i < LOAD_STAGE) && match[p][i] && trk_ld_q[i]) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    always_comb begin
        opd     = rf_rdata;
        fwd_hit = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            // Walk oldest to youngest so the youngest matching stage is written last.
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (match[p][NUM_STAGES-1-k]) begin
                    opd[p*REG_WIDTH +: REG_WIDTH] =
                        stg_data[(NUM_STAGES-1-k)*REG_WIDTH +: REG_WIDTH];
                    fwd_hit[p] = 1'b1;
                end
            end
        end
    end

    // Outputs depend only on state and resolve inputs, keeping issue out of a comb loop.
    always_comb begin
        flush   = 1'b0;
        if_hold = 1'b0;
        if (BR_MODE == 0) begin
            if (state_q == ST_WAIT) begin
                if_hold = 1'b1;
                flush   = br_resolve && br_taken;
            end
        end else begin
            flush = (state_q == ST_FLUSH);
        end
    end

    assign id_stall = id_valid && !flush && load_use;
    assign issue    = id_valid && !id_stall && !flush && !if_hold;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (BR_MODE == 0) begin
            case (state_q)
                ST_RUN: begin
                    if (issue && id_is_ctrl) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (br_resolve) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (br_resolve && br_taken) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LEN;
                    end
                end
                ST_FLUSH: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        trk_rd_d    = trk_rd_q;
        trk_we_d    = trk_we_q;
        trk_ld_d    = trk_ld_q;
        trk_rd_d[0] = issue ? id_rd_adr : '0;
        trk_we_d[0] = issue && id_rd_we && (id_rd_adr != '0);
        trk_ld_d[0] = issue && id_is_load;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            trk_rd_d[i] = trk_rd_q[i-1];
            trk_we_d[i] = trk_we_q[i-1];
            trk_ld_d[i] = trk_ld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            trk_rd_q <= '{default: '0};
            trk_we_q <= '0;
            trk_ld_q <= '0;
            state_q  <= ST_RUN;
            cnt_q    <= '0;
        end else begin
            trk_rd_q <= trk_rd_d;
            trk_we_q <= trk_we_d;
            trk_ld_q <= trk_ld_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: one instance per branch mode, directed vector table,
// hand-written control/reset sequences and random stimulus against a queue-style model.
module tb_riscv_hazard_ctrl;

    localparam int RW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int NS = 3;
    localparam int LS = 1;
    localparam int FC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              id_valid;
    logic [NP*AW-1:0]  id_rs_adr;
    logic [NP-1:0]     id_rs_used;
    logic [AW-1:0]     id_rd_adr;
    logic              id_rd_we;
    logic              id_is_load;
    logic              id_is_ctrl;
    logic [NP*RW-1:0]  rf_rdata;
    logic [NS*RW-1:0]  stg_data;
    logic              br_resolve;
    logic              br_taken;

    logic [NP*RW-1:0]  d0_opd, d1_opd;
    logic [NP-1:0]     d0_hit, d1_hit;
    logic              d0_stall, d1_stall, d0_hold, d1_hold, d0_flush, d1_flush;

    riscv_hazard_ctrl #(.BR_MODE(0), .FLUSH_CYCLES(FC)) dut0 (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs_adr(id_rs_adr),
        .id_rs_used(id_rs_used), .id_rd_adr(id_rd_adr), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl), .rf_rdata(rf_rdata),
        .stg_data(stg_data), .br_resolve(br_resolve), .br_taken(br_taken),
        .opd(d0_opd), .fwd_hit(d0_hit), .id_stall(d0_stall), .if_hold(d0_hold),
        .flush(d0_flush)
    );

    riscv_hazard_ctrl #(.BR_MODE(1), .FLUSH_CYCLES(FC)) dut1 (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs_adr(id_rs_adr),
        .id_rs_used(id_rs_used), .id_rd_adr(id_rd_adr), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl), .rf_rdata(rf_rdata),
        .stg_data(stg_data), .br_resolve(br_resolve), .br_taken(br_taken),
        .opd(d1_opd), .fwd_hit(d1_hit), .id_stall(d1_stall), .if_hold(d1_hold),
        .flush(d1_flush)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per mode, list of in-flight writers (index 0 = youngest), a waiting flag
    // for mode 0 and a remaining-flush-cycles count for mode 1.
    bit [AW-1:0] mrd   [2][NS];
    bit          mwe   [2][NS];
    bit          mld   [2][NS];
    bit          mwait [2];
    int          mleft [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NS; i++) begin
                mrd[m][i] = '0;
                mwe[m][i] = 1'b0;
                mld[m][i] = 1'b0;
            end
            mwait[m] = 1'b0;
            mleft[m] = 0;
        end
    endtask

    function automatic bit mmatch(input int m, input int p, input int i);
        bit [AW-1:0] rs;
        rs = id_rs_adr[p*AW +: AW];
        return id_rs_used[p] && (rs != 0) && mwe[m][i] && (mrd[m][i] == rs);
    endfunction

    task automatic model_eval(input int m, output logic [NP*RW-1:0] o, output logic [NP-1:0] h,
                              output logic st, output logic ih, output logic fl,
                              output logic iss);
        bit lu;
        bit found;
        fl = (m == 1) ? (mleft[m] > 0) : (mwait[m] && br_resolve && br_taken);
        ih = (m == 0) && mwait[m];
        o  = rf_rdata;
        h  = '0;
        lu = 1'b0;
        for (int p = 0; p < NP; p++) begin
            found = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (!found && mmatch(m, p, i)) begin
                    o[p*RW +: RW] = stg_data[i*RW +: RW];
                    h[p]  = 1'b1;
                    found = 1'b1;
                end
            end
            for (int i = 0; i < LS; i++) begin
                if (mmatch(m, p, i) && mld[m][i]) lu = 1'b1;
            end
        end
        st  = id_valid && !fl && lu;
        iss = id_valid && !st && !fl && !ih;
    endtask

    task automatic model_update();
        logic [NP*RW-1:0] o;
        logic [NP-1:0]    h;
        logic             st, ih, fl, iss;
        if (!resetn) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            model_eval(m, o, h, st, ih, fl, iss);
            for (int i = NS - 1; i > 0; i--) begin
                mrd[m][i] = mrd[m][i-1];
                mwe[m][i] = mwe[m][i-1];
                mld[m][i] = mld[m][i-1];
            end
            mrd[m][0] = iss ? id_rd_adr : '0;
            mwe[m][0] = iss && id_rd_we && (id_rd_adr != 0);
            mld[m][0] = iss && id_is_load;
            if (m == 1) begin
                if (mleft[1] > 0) mleft[1]--;
                else if (br_resolve && br_taken) mleft[1] = FC;
            end else begin
                if (mwait[0]) begin
                    if (br_resolve) mwait[0] = 1'b0;
                end else if (iss && id_is_ctrl) begin
                    mwait[0] = 1'b1;
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs applied; ends just after the next one.
    task automatic tick();
        logic [NP*RW-1:0] o;
        logic [NP-1:0]    h;
        logic             st, ih, fl, iss;
        #1;
        model_eval(0, o, h, st, ih, fl, iss);
        chk("m0_opd", d0_opd, o);
        chk("m0_hit", d0_hit, h);
        chk("m0_stall", d0_stall, st);
        chk("m0_hold", d0_hold, ih);
        chk("m0_flush", d0_flush, fl);
        model_eval(1, o, h, st, ih, fl, iss);
        chk("m1_opd", d1_opd, o);
        chk("m1_hit", d1_hit, h);
        chk("m1_stall", d1_stall, st);
        chk("m1_hold", d1_hold, ih);
        chk("m1_flush", d1_flush, fl);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_rs_adr  = '0;
        id_rs_used = '0;
        id_rd_adr  = '0;
        id_rd_we   = 1'b0;
        id_is_load = 1'b0;
        id_is_ctrl = 1'b0;
        rf_rdata   = {32'h0, 32'h42};
        stg_data   = {32'h555, 32'h444, 32'h333};
        br_resolve = 1'b0;
        br_taken   = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          va;
        bit [4:0]    rs;
        bit          us;
        bit [4:0]    rd;
        bit          we;
        bit          ld;
        bit          res;
        bit          tkn;
        bit [31:0]   rf;
        bit [31:0]   s0, s1, s2;
        bit [31:0]   eo;
        bit          eh;
        bit          es;
        bit          ef;
    } vec_t;

    function automatic vec_t v(string n, bit va, bit [4:0] rs, bit us, bit [4:0] rd, bit we,
                               bit ld, bit res, bit tkn, bit [31:0] rf, bit [31:0] s0,
                               bit [31:0] s1, bit [31:0] s2, bit [31:0] eo, bit eh, bit es,
                               bit ef);
        vec_t r;
        r.name = n; r.va = va; r.rs = rs; r.us = us; r.rd = rd; r.we = we; r.ld = ld;
        r.res = res; r.tkn = tkn; r.rf = rf; r.s0 = s0; r.s1 = s1; r.s2 = s2;
        r.eo = eo; r.eh = eh; r.es = es; r.ef = ef;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        // Mode-1 instance expectations, applied one row per cycle from reset.
        tbl.push_back(v("rst",     0, 5, 1, 0, 0, 0, 0, 0, 'h55, 'h1234, 'h2,    'h3,   'h55,   0, 0, 0));
        tbl.push_back(v("wr5",     1, 0, 0, 5, 1, 0, 0, 0, 'h0,  'h1234, 'h2,    'h3,   'h0,    0, 0, 0));
        tbl.push_back(v("fwd5",    1, 5, 1, 0, 0, 0, 0, 0, 'h0,  'h1234, 'h2,    'h3,   'h1234, 1, 0, 0));
        tbl.push_back(v("fwd5_s1", 0, 5, 1, 0, 0, 0, 0, 0, 'h0,  'h1111, 'h777,  'h3,   'h777,  1, 0, 0));
        tbl.push_back(v("fwd5_s2", 0, 5, 1, 0, 0, 0, 0, 0, 'h0,  'h1111, 'h2222, 'h999, 'h999,  1, 0, 0));
        tbl.push_back(v("w7a",     1, 0, 0, 7, 1, 0, 0, 0, 'h42, 'hA,    'hB,    'hC,   'h42,   0, 0, 0));
        tbl.push_back(v("w7b",     1, 0, 0, 7, 1, 0, 0, 0, 'h42, 'hA,    'hB,    'hC,   'h42,   0, 0, 0));
        tbl.push_back(v("pri",     0, 7, 1, 0, 0, 0, 0, 0, 'h42, 'hA,    'hB,    'hC,   'hA,    1, 0, 0));
        tbl.push_back(v("w0a",     1, 0, 0, 0, 1, 0, 0, 0, 'h42, 'hA,    'hB,    'hC,   'h42,   0, 0, 0));
        tbl.push_back(v("w0b",     1, 0, 0, 0, 1, 0, 0, 0, 'h42, 'hA,    'hB,    'hC,   'h42,   0, 0, 0));
        tbl.push_back(v("x0",      0, 0, 1, 0, 0, 0, 0, 0, 'h42, 'hA,    'hB,    'hC,   'h42,   0, 0, 0));
        tbl.push_back(v("ld3",     1, 0, 0, 3, 1, 1, 0, 0, 'h42, 'h333,  'h444,  'h555, 'h42,   0, 0, 0));
        tbl.push_back(v("use3",    1, 3, 1, 9, 1, 0, 0, 0, 'h42, 'h333,  'h444,  'h555, 'h333,  1, 1, 0));
        tbl.push_back(v("use3b",   1, 3, 1, 9, 1, 0, 0, 0, 'h42, 'h333,  'h444,  'h555, 'h444,  1, 0, 0));
        tbl.push_back(v("res_t",   1, 0, 0, 0, 0, 0, 1, 1, 'h42, 'h333,  'h444,  'h555, 'h42,   0, 0, 0));
        tbl.push_back(v("fl1",     1, 0, 0, 11, 1, 0, 0, 0, 'h42, 'h333, 'h444,  'h555, 'h42,   0, 0, 1));
        tbl.push_back(v("fl2",     1, 11, 1, 12, 1, 0, 0, 0, 'h42, 'h333, 'h444, 'h555, 'h42,   0, 0, 1));
        tbl.push_back(v("fl_end",  1, 12, 1, 13, 1, 1, 0, 0, 'h42, 'h333, 'h444, 'h555, 'h42,   0, 0, 0));
        tbl.push_back(v("nt_use",  1, 13, 1, 0, 0, 0, 1, 0, 'h42, 'h333, 'h444,  'h555, 'h333,  1, 1, 0));
        tbl.push_back(v("nt_chk",  1, 13, 1, 0, 0, 0, 0, 0, 'h42, 'h333, 'h444,  'h555, 'h444,  1, 0, 0));
        tbl.push_back(v("ld4_res", 1, 0, 0, 4, 1, 1, 1, 1, 'h42, 'h333,  'h444,  'h555, 'h42,   0, 0, 0));
        tbl.push_back(v("fl_ld",   1, 4, 1, 0, 0, 0, 0, 0, 'h42, 'h333,  'h444,  'h555, 'h333,  1, 0, 1));
        tbl.push_back(v("fl_ign",  1, 4, 1, 0, 0, 0, 1, 1, 'h42, 'h333,  'h444,  'h555, 'h444,  1, 0, 1));
        tbl.push_back(v("fl_done", 0, 0, 0, 0, 0, 0, 0, 0, 'h42, 'h333,  'h444,  'h555, 'h42,   0, 0, 0));

        idle();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[k]) begin
            id_valid   = tbl[k].va;
            id_rs_adr  = {5'd0, tbl[k].rs};
            id_rs_used = {1'b0, tbl[k].us};
            id_rd_adr  = tbl[k].rd;
            id_rd_we   = tbl[k].we;
            id_is_load = tbl[k].ld;
            id_is_ctrl = 1'b0;
            br_resolve = tbl[k].res;
            br_taken   = tbl[k].tkn;
            rf_rdata   = {32'h0, tbl[k].rf};
            stg_data   = {tbl[k].s2, tbl[k].s1, tbl[k].s0};
            #1;
            chk($sformatf("%s_opd", tbl[k].name), 64'(d1_opd[31:0]), 64'(tbl[k].eo));
            chk($sformatf("%s_hit", tbl[k].name), 64'(d1_hit[0]), 64'(tbl[k].eh));
            chk($sformatf("%s_stall", tbl[k].name), 64'(d1_stall), 64'(tbl[k].es));
            chk($sformatf("%s_flush", tbl[k].name), 64'(d1_flush), 64'(tbl[k].ef));
            chk($sformatf("%s_hold", tbl[k].name), 64'(d1_hold), 64'(0));
            tick();
        end

        // Mode 0: JAL that is also flagged as a load, resolved taken in the first wait cycle.
        idle();
        id_valid = 1'b1; id_is_ctrl = 1'b1; id_is_load = 1'b1; id_rd_adr = 5'd1; id_rd_we = 1'b1;
        #1 chk("jal_hold0", 64'(d0_hold), 64'(0));
        tick();
        idle();
        id_valid = 1'b1; id_rs_adr = {5'd0, 5'd1}; id_rs_used = 2'b01;
        br_resolve = 1'b1; br_taken = 1'b1;
        #1;
        chk("jal_res_hold", 64'(d0_hold), 64'(1));
        chk("jal_res_flush", 64'(d0_flush), 64'(1));
        chk("jal_res_stall", 64'(d0_stall), 64'(0));
        tick();
        idle();
        #1;
        chk("jal_after_hold", 64'(d0_hold), 64'(0));
        chk("jal_after_flush", 64'(d0_flush), 64'(0));
        tick();

        // Mode 0: hold across several cycles, then a not-taken resolve.
        idle();
        id_valid = 1'b1; id_is_ctrl = 1'b1; id_rd_adr = 5'd1; id_rd_we = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            idle();
            #1;
            chk("wait_hold", 64'(d0_hold), 64'(1));
            chk("wait_flush", 64'(d0_flush), 64'(0));
            tick();
        end
        idle();
        br_resolve = 1'b1;
        #1;
        chk("nt_hold", 64'(d0_hold), 64'(1));
        chk("nt_flush", 64'(d0_flush), 64'(0));
        tick();
        idle();
        #1 chk("nt_after_hold", 64'(d0_hold), 64'(0));
        tick();
        idle();
        br_resolve = 1'b1; br_taken = 1'b1;
        #1 chk("run_res_flush", 64'(d0_flush), 64'(0));
        tick();
        idle();
        #1 chk("run_res_hold", 64'(d0_hold), 64'(0));
        tick();
        idle();
        repeat (3) tick();

        // Asynchronous reset mid-FLUSH (mode 1) and mid-WAIT (mode 0).
        id_valid = 1'b1; id_is_ctrl = 1'b1; id_rd_adr = 5'd2; id_rd_we = 1'b1;
        br_resolve = 1'b1; br_taken = 1'b1;
        tick();
        idle();
        id_valid = 1'b1; id_rs_adr = {5'd0, 5'd2}; id_rs_used = 2'b01;
        rf_rdata = {32'h0, 32'h77};
        #1;
        chk("pre_rst_flush", 64'(d1_flush), 64'(1));
        chk("pre_rst_hold", 64'(d0_hold), 64'(1));
        #1 resetn = 1'b0;
        #1;
        chk("rst_flush", 64'(d1_flush), 64'(0));
        chk("rst_hold", 64'(d0_hold), 64'(0));
        chk("rst_opd", 64'(d1_opd[31:0]), 64'h77);
        chk("rst_hit", 64'(d1_hit), 64'(0));
        chk("rst_stall", 64'(d1_stall), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle();
        #1;
        chk("post_rst_flush", 64'(d1_flush), 64'(0));
        chk("post_rst_hold", 64'(d0_hold), 64'(0));
        tick();
        #1 chk("post_rst_flush2", 64'(d1_flush), 64'(0));
        tick();

        for (int n = 0; n < 1500; n++) begin
            id_valid   = ($urandom_range(0, 9) < 8);
            for (int p = 0; p < NP; p++) begin
                id_rs_adr[p*AW +: AW] = 5'($urandom_range(0, 7));
                id_rs_used[p]         = 1'($urandom_range(0, 1));
                rf_rdata[p*RW +: RW]  = $urandom;
            end
            for (int i = 0; i < NS; i++) stg_data[i*RW +: RW] = $urandom;
            id_rd_adr  = 5'($urandom_range(0, 7));
            id_rd_we   = ($urandom_range(0, 3) != 0);
            id_is_load = ($urandom_range(0, 3) == 0);
            id_is_ctrl = ($urandom_range(0, 9) == 0);
            br_resolve = ($urandom_range(0, 4) == 0);
            br_taken   = 1'($urandom_range(0, 1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Parametrised hazard and operand-bypass controller for the in-order RISC-V pipeline (IF → ID → EX → LSU → RUU). It replaces the blanket branch/jump stall and fixed two-level bypass in the CPU top. It tracks in-flight destinations over a configurable number of stages, detects load-use hazards, and forwards the youngest matching result to any number of read ports. Control hazards are handled in one of two modes: stall-until-resolve or predict-not-taken with a timed flush.

## Interface
Parameters:
- REG_WIDTH, 32: data width.
- REG_ADDR_WIDTH, 5: register address width.
- NUM_RD_PORTS, 2: operand read ports in ID.
- NUM_STAGES, 3: tracked stages after ID. Index 0 = EX, 1 = LSU, 2 = RUU.
- LOAD_STAGE, 1: first stage index at which load data is valid on stg_data.
- BR_MODE, 1: 0 = stall-on-control, 1 = predict-not-taken plus flush.
- FLUSH_CYCLES, 2: flush length in mode 1, range 1..15.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs_adr  in  NUM_RD_PORTS*REG_ADDR_WIDTH  source addresses. Port p sits at slice p.
- id_rs_used  in  NUM_RD_PORTS  port p actually reads its source.
- id_rd_adr  in  REG_ADDR_WIDTH  destination address of the ID instruction.
- id_rd_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_is_ctrl  in  1  ID instruction is BRANCH, JAL or JALR.
- rf_rdata  in  NUM_RD_PORTS*REG_WIDTH  register-file read data.
- stg_data  in  NUM_STAGES*REG_WIDTH  result currently held by stage i.
- br_resolve  in  1  single-cycle pulse: EX resolved a control instruction.
- br_taken  in  1  qualifies br_resolve; 1 = redirect.
- opd  out  NUM_RD_PORTS*REG_WIDTH  bypassed operands for ID.
- fwd_hit  out  NUM_RD_PORTS  port p was served from a stage, not rf_rdata.
- id_stall  out  1  hold IF/ID and inject a bubble into EX.
- if_hold  out  1  hold PC and feed a NOP into IF/ID (mode 0 only).
- flush  out  1  kill the IF/ID contents; the pipeline loads the redirect target.

## Operation
- Tracker: NUM_STAGES entries of {rd, we, ld}.
  - Each cycle, entry i takes entry i-1. Later stages never stall.
  - Entry 0 takes {id_rd_adr, id_rd_we && id_rd_adr != 0, id_is_load} when issue = id_valid && !id_stall && !flush && !if_hold. Otherwise entry 0 takes a bubble (we=0).
- A port match for port p at stage i requires all of: id_rs_used[p], rs != 0, entry i we, and entry i rd == rs.
- Load-use hazard: id_stall = id_valid && !flush && some port matches at a stage i < LOAD_STAGE whose entry has ld=1.
- Forwarding, per port:
  - The lowest-index (youngest) matching stage supplies opd from stg_data[i], and fwd_hit = 1.
  - With no match, opd = rf_rdata and fwd_hit = 0.
  - x0 never forwards.
  - Forwarding is purely combinational.
- Control FSM, BR_MODE 0 (states RUN and WAIT):
  - RUN → WAIT when a control instruction issues.
  - In WAIT, if_hold = 1.
  - WAIT → RUN on br_resolve. If br_taken, flush = 1 in that same cycle.
  - br_resolve in RUN is ignored.
- Control FSM, BR_MODE 1 (states RUN and FLUSH, 4-bit counter):
  - if_hold is tied to 0.
  - br_resolve && br_taken in RUN loads cnt = FLUSH_CYCLES and moves to FLUSH.
  - In FLUSH: flush = 1, cnt decrements each cycle, and the FSM returns to RUN when cnt reaches 1.
  - br_resolve during FLUSH is ignored; it comes from a killed instruction.
- Precedence: flush forces id_stall = 0 and blocks issue. A load-use stall never delays a redirect.

## Timing
- Reset (asynchronous): tracker all bubbles, FSM = RUN, cnt = 0.
  - id_stall, if_hold and flush are 0.
  - opd = rf_rdata and fwd_hit = 0 (combinational).
- id_stall is same-cycle combinational from the tracker and ID inputs.
- Load-use stall length is LOAD_STAGE cycles for a dependent directly behind a load (default 1).
- Mode 1 flush:
  - flush asserts in the cycle after the taken resolve.
  - It stays high for exactly FLUSH_CYCLES cycles.
  - The first issue is allowed in the following cycle.
- Mode 0 flush: flush is coincident with br_resolve. if_hold deasserts in the cycle after resolve.
- Reset asserted mid-FLUSH or mid-WAIT returns to RUN immediately. No residual flush pulse appears after resetn rises.

## Test plan
- Back-to-back ALU forward: issue x5 write then a read of x5 on port 0, with stg_data[0] = 0x1234 and rf = 0.
  - Required: opd[0] = 0x1234, fwd_hit[0] = 1, id_stall = 0.
- Priority: x7 in flight at stages 0 and 1, with stg_data 0xA and 0xB.
  - Required: opd = 0xA.
  - With rd = x0 instead: opd = rf_rdata.
- Load-use: issue a load to x3 then a dependent on x3.
  - Required: id_stall = 1 for exactly 1 cycle.
  - The next cycle the dependent gets stg_data[1] and the tracker shows a bubble at entry 0.
- Mode 1 taken branch (FLUSH_CYCLES = 2): br_resolve = 1, br_taken = 1 at cycle t.
  - Required: flush = 1 at cycles t+1 and t+2, issue blocked at both, and 0 at t+3.
  - A not-taken resolve produces no flush.
- Mode 0: a JAL issues.
  - Required: if_hold = 1 until br_resolve.
  - flush pulses exactly in the resolve cycle.
  - A simultaneous load-use condition yields id_stall = 0.
- Reset: drop resetn during FLUSH with cnt = 2.
  - Required: outputs go to reset values asynchronously.
  - After release, RUN with no flush.
